// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT front-end defaults and frame reader state encoding
package fft_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int N_POINTS_DEF = 32;
    localparam int ADDR_W_DEF   = $clog2(N_POINTS_DEF);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/bit_reverse.sv
// rtl/bit_reverse.sv - combinational bit reversal of an index, shared by the FFT stages
import fft_pkg::*;

module bit_reverse #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout
);

    genvar b;
    generate
        for (b = 0; b < ADDR_W; b++) begin : g_rev
            assign dout[b] = din[ADDR_W-1-b];
        end
    endgenerate

endmodule

// File: rtl/bitrev_frame_reader.sv
// rtl/bitrev_frame_reader.sv - frame buffer written in natural order, read out in bit-reversed order
import fft_pkg::*;

module bitrev_frame_reader #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int N_POINTS = N_POINTS_DEF,
    localparam int ADDR_W  = $clog2(N_POINTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_idx;
    logic              wr_en;
    logic              rd_xfer;
    logic              draining;
    logic [DATA_W-1:0] mem [N_POINTS];

    bit_reverse #(
        .ADDR_W(ADDR_W)
    ) u_bit_reverse (
        .din (rd_cnt),
        .dout(rd_idx)
    );

    // Next state and handshake outputs; the frame boundary is the last write / last transfer
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        wr_en     = 1'b0;
        rd_xfer   = 1'b0;
        case (state_q)
            ST_FILL: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                if (in_valid && (wr_cnt == LAST_IDX)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (rd_cnt == LAST_IDX);
                rd_xfer   = out_ready;
                if (out_ready && (rd_cnt == LAST_IDX)) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Write and read counters; both wrap naturally at the power-of-two frame length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (rd_xfer) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Sample storage, cleared on reset so a discarded frame never leaks out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_POINTS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_cnt] <= in_data;
        end
    end

    // Read data is driven only while draining so idle outputs stay at zero
    assign draining  = (state_q == ST_DRAIN);
    assign out_index = draining ? rd_idx : '0;
    assign out_data  = draining ? mem[rd_idx] : '0;
    assign busy      = draining || (wr_cnt != '0);

endmodule

// File: tb/tb_bitrev_frame_reader.sv
// tb/tb_bitrev_frame_reader.sv - randomized bench with frame-level reference model for bitrev_frame_reader
module tb_bitrev_frame_reader;

    localparam int DW = 16;
    localparam int N  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    bitrev_frame_reader #(
        .DATA_W  (DW),
        .N_POINTS(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .busy     (busy)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] idx;
    } exp_t;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] frame_buf [N];
    int            m_acc = 0;
    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    int            busy_low_cycs[$];
    int            last_acc_cyc = 0;
    int            first_valid_cyc = 0;
    int            last_xfer_cyc = 0;
    int            frame_start_cyc = 0;
    bit            prev_valid = 0;
    bit            stall_prev = 0;
    logic [DW-1:0] prev_d;
    logic [AW-1:0] prev_i;
    logic          prev_l;
    int            ready_mode = 0;
    int            tog = 0;

    function automatic logic [AW-1:0] rev(input int v);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (tog % 3 == 0); tog++; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Compare process: check outputs against the frame model, then advance the model by the coming edge
    always @(negedge clk) begin
        bit ev;
        if (rst) begin
            exp_q.delete();
            m_acc = 0;
            stall_prev = 0;
            prev_valid = 0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_index", out_index, 0);
            chk("rst_out_data", out_data, 0);
        end else begin
            ev = (exp_q.size() != 0);
            chk("in_ready", in_ready, !ev);
            chk("out_valid", out_valid, ev);
            chk("busy", busy, ev || (m_acc != 0));
            if (ev) begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_index", out_index, exp_q[0].idx);
                chk("out_last", out_last, exp_q.size() == 1);
            end else begin
                chk("out_last_idle", out_last, 0);
            end
            if (stall_prev) begin
                chk("stall_data", out_data, prev_d);
                chk("stall_index", out_index, prev_i);
                chk("stall_last", out_last, prev_l);
            end
            if (!busy) busy_low_cycs.push_back(cyc);
            if (out_valid && !prev_valid) first_valid_cyc = cyc;
            prev_valid = out_valid;
            if (!ev && in_valid) begin
                if (m_acc == 0) frame_start_cyc = cyc;
                frame_buf[m_acc] = in_data;
                m_acc++;
                if (m_acc == N) begin
                    for (int j = 0; j < N; j++)
                        exp_q.push_back('{d: frame_buf[rev(j)], idx: rev(j)});
                    m_acc = 0;
                    last_acc_cyc = cyc;
                end
            end
            if (ev && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) last_xfer_cyc = cyc;
            end
            stall_prev = ev && !out_ready;
            prev_d = out_data;
            prev_i = out_index;
            prev_l = out_last;
        end
    end

    task automatic send_frame(input int base, input int mode);
        int k = 0;
        int guard = 0;
        int g3 = 0;
        bit acc;
        while (k < N && guard < 3000) begin
            case (mode)
                1: in_valid = ((g3 % 3) != 2);
                2: in_valid = 1'($urandom_range(0, 1));
                default: in_valid = 1'b1;
            endcase
            g3++;
            in_data = (base < 0) ? DW'($urandom) : DW'(base + k);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            guard++;
        end
        chk("send_timeout", k, N);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_timeout", exp_q.size() == 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int nl;
        int g;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // natural ramp, full-rate drain
        got_d.delete(); got_l.delete();
        send_frame(0, 0);
        in_valid = 1'b0;
        wait_idle();
        chk("seq_len", got_d.size(), 32);
        chk("seq0", got_d[0], 0);
        chk("seq1", got_d[1], 16);
        chk("seq2", got_d[2], 8);
        chk("seq3", got_d[3], 24);
        chk("seq4", got_d[4], 4);
        chk("seq5", got_d[5], 20);
        chk("seq30", got_d[30], 15);
        chk("seq31", got_d[31], 31);
        nl = 0;
        foreach (got_l[i]) if (got_l[i]) nl++;
        chk("last_count", nl, 1);
        chk("last_on_31", got_l[31], 1);

        // same frame with stalling consumer
        got_d.delete(); got_l.delete();
        tog = 0;
        ready_mode = 1;
        send_frame(0, 0);
        in_valid = 1'b0;
        wait_idle();
        chk("stall_seq_len", got_d.size(), 32);
        for (int i = 0; i < N; i++) chk("stall_seq", got_d[i], 32'(rev(i)));

        // gapped writer, junk offered during drain, then random frame
        ready_mode = 0;
        send_frame(64, 1);
        in_valid = 1'b1;
        in_data = 16'hFFFF;
        wait_idle();
        in_valid = 1'b0;
        chk("drain_latency", first_valid_cyc - last_acc_cyc, 1);
        ready_mode = 2;
        send_frame(-1, 0);
        in_valid = 1'b0;
        wait_idle();

        // back-to-back frames at full throughput
        ready_mode = 0;
        got_d.delete(); got_l.delete();
        busy_low_cycs.delete();
        send_frame(100, 0);
        t0 = frame_start_cyc;
        send_frame(200, 0);
        in_valid = 1'b0;
        wait_idle();
        chk("b2b_cycles", last_xfer_cyc - t0 + 1, 128);
        nl = 0;
        foreach (busy_low_cycs[i]) if (busy_low_cycs[i] > t0 && busy_low_cycs[i] <= last_xfer_cyc) nl++;
        chk("b2b_busy_low", nl, 1);
        chk("b2b_f2_0", got_d[32], 200);
        chk("b2b_f2_1", got_d[33], 216);
        chk("b2b_f2_2", got_d[34], 208);
        chk("b2b_f2_31", got_d[63], 231);

        // reset during drain at read count 7
        send_frame(50, 0);
        in_valid = 1'b0;
        g = 0;
        while (exp_q.size() != 25 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("reach_rd7", exp_q.size(), 25);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);
        got_d.delete(); got_l.delete();
        send_frame(0, 0);
        in_valid = 1'b0;
        wait_idle();
        chk("post_rst_first", got_d[0], 0);
        chk("post_rst_second", got_d[1], 16);

        // random traffic
        ready_mode = 2;
        repeat (6) send_frame(-1, 2);
        in_valid = 1'b0;
        wait_idle();

        // reset mid-fill discards the partial frame
        ready_mode = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = DW'(900 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        got_d.delete(); got_l.delete();
        send_frame(300, 0);
        in_valid = 1'b0;
        wait_idle();
        chk("fill_rst_first", got_d[0], 300);
        chk("fill_rst_second", got_d[1], 316);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitrev_frame_reader.md
BITREV_FRAME_READER -- requirements
Module: bitrev_frame_reader

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits.
REQ-002 Parameter N_POINTS, default 32, frame length; SHALL be a power of two; ADDR_W = log2(N_POINTS), 5 by default.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  writer presents a sample.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 in_data  input  DATA_W  sample, natural (time) order.
REQ-008 out_valid  output  1  reader-side sample available.
REQ-009 out_ready  input  1  downstream (FFT stage 0) accepts.
REQ-010 out_data  output  DATA_W  sample, bit-reversed order.
REQ-011 out_index  output  ADDR_W  natural-order index of the sample on out_data.
REQ-012 out_last  output  1  high with the final sample of a frame.
REQ-013 busy  output  1  high while a partial or full frame is held.

Function
REQ-014 Two-state FSM: FILL, DRAIN.
REQ-015 FILL: in_ready = 1, out_valid = 0; each cycle with in_valid=1 SHALL write in_data to mem[wr_cnt] and increment wr_cnt.
REQ-016 FILL -> DRAIN on the edge accepting the sample with wr_cnt = N_POINTS-1; wr_cnt wraps to 0 on that edge.
REQ-017 DRAIN: in_ready = 0, out_valid = 1; in_valid is ignored (no write, no count).
REQ-018 DRAIN: out_index = bitrev(rd_cnt) over ADDR_W bits, out_data = mem[out_index], both valid combinationally from registered rd_cnt.
REQ-019 Transfer occurs on an edge where out_valid=1 and out_ready=1; rd_cnt SHALL increment only on transfer.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-021 out_last = 1 exactly when state = DRAIN and rd_cnt = N_POINTS-1.
REQ-022 DRAIN -> FILL on the transfer with out_last=1; rd_cnt wraps to 0.
REQ-023 Latency: first out_valid in the cycle immediately after the edge accepting sample N_POINTS-1; in_ready reasserts in the cycle after the last-sample transfer.
REQ-024 Full-throughput case (in_valid, out_ready held 1): one frame every 2*N_POINTS cycles, no bubble between phases.
REQ-025 busy = 1 when state = DRAIN or wr_cnt != 0.
REQ-026 Storage: N_POINTS x DATA_W register array; no arithmetic on data.

Reset
REQ-027 On rst=1, regardless of clk: state = FILL, wr_cnt = 0, rd_cnt = 0, all mem entries = 0.
REQ-028 Reset outputs: in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_index = 0, out_data = 0.
REQ-029 Reset mid-FILL or mid-DRAIN SHALL discard the frame; first post-reset accepted sample is index 0 of a new frame.

Structure
REQ-030 Shared package fft_pkg SHALL hold N_POINTS, ADDR_W, DATA_W defaults and the FSM state encoding.
REQ-031 Sub-module bit_reverse (combinational, ADDR_W in/out) SHALL compute out_index from rd_cnt; it is reused by later FFT stages.

Verification
REQ-032 Reset during DRAIN at rd_cnt=7 -> next cycle in_ready=1, out_valid=0, busy=0; new frame 0..31 drains starting with value 0.
REQ-033 Write frame data=k for k=0..31, out_ready=1 -> out_data sequence 0,16,8,24,4,20,...,15,31; out_last only on 31.
REQ-034 Same frame, out_ready toggled 1,0,0,1,... -> identical sequence, outputs stable during stalls, no loss or duplication.
REQ-035 in_valid gapped every 3rd cycle -> DRAIN starts exactly one cycle after the 32nd accept; in_valid=1 during DRAIN with data 0xFFFF -> no effect on next frame.
REQ-036 Two back-to-back frames (100+k, then 200+k) with in_valid=out_ready=1 -> 128-cycle total, second frame drains 200,216,208,...; busy low only between frames.
